dpu_sprite_engine: RTL and testbench
====================================

DPU_SPRITE_ENGINE -- requirements
Module: dpu_sprite_engine

Parameters
REQ-001 SHALL: H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48 -- horizontal timing in pixel clocks.
REQ-002 SHALL: V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33 -- vertical timing in lines.
REQ-003 SHALL: NUM_SPR=4, SPR_W=16, SPR_H=16 -- sprite count and sprite size in pixels.
REQ-004 SHALL: COORD_W=11, COLOR_W=8 -- coordinate and color widths.
REQ-005 SHALL: BG_COLOR=8'h00 -- active-area background color; SYNC_POL=0 -- sync pulse level; Y_INVERT=0, Y_BASE=500 -- when Y_INVERT=1, screen y = Y_BASE - cfg_y, modulo 2^COORD_W.

Interface
REQ-006 SHALL: clk  in  1  pixel clock (single clock domain).
REQ-007 SHALL: rst  in  1  synchronous, active-high reset.
REQ-008 SHALL: cfg_valid  in  1  sprite config write request.
REQ-009 SHALL: cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
REQ-010 SHALL: cfg_idx  in  clog2(NUM_SPR)  target sprite.
REQ-011 SHALL: cfg_x, cfg_y  in  COORD_W each  sprite top-left position.
REQ-012 SHALL: cfg_en  in  1  sprite visible; cfg_flip  in  1  horizontal mirror; cfg_color  in  COLOR_W  sprite color.
REQ-013 SHALL: sprite_bitmap  in  NUM_SPR*SPR_H*SPR_W  flattened bitmaps; bit (s*SPR_H + row)*SPR_W + col.
REQ-014 SHALL: hsync, vsync  out  1 each  sync outputs, aligned with color.
REQ-015 SHALL: color  out  COLOR_W  pixel color; at_display  out  1  active-area flag.
REQ-016 SHALL: frame_start  out  1  one-cycle pulse at Hcnt=0, Vcnt=0.
REQ-017 SHALL: frame_cnt  out  8  completed-frame counter.

Function
REQ-018 SHALL: Hcnt counts 0..H_TOTAL-1 (H_TOTAL = sum of the H params), then wraps to 0; Vcnt increments on each Hcnt wrap and wraps after V_TOTAL-1.
REQ-019 SHALL: the raw hsync is active (==SYNC_POL) for H_ACTIVE+H_FP <= Hcnt < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule with the V params.
REQ-020 SHALL: the sprite block has a shadow register set (written by cfg) and an active set (used for drawing).
REQ-021 SHALL: an accepted write updates only shadow[cfg_idx], on the accepting clock edge.
REQ-022 SHALL: commit (shadow -> active, all sprites atomically) occurs on the cycle where Hcnt=0 and Vcnt=V_ACTIVE (start of vblank).
REQ-023 SHALL: cfg_ready is 0 on the commit cycle and 1 otherwise out of reset, so no write coincides with a commit.
REQ-024 SHALL: sprite s hits pixel (Hcnt,Vcnt) iff active.en, 0<=Hcnt-x<SPR_W, 0<=Vcnt-y_eff<SPR_H, and the bitmap bit is 1; comparisons use COORD_W+1-bit signed differences, with no wrap hits.
REQ-025 SHALL: when flip=1, col = SPR_W-1-(Hcnt-x); otherwise col = Hcnt-x.
REQ-026 SHALL: priority is fixed, with the lowest sprite index winning; if no sprite hits, the pixel is BG_COLOR; outside the active area, color=0.
REQ-027 SHALL: all outputs are registered, with latency exactly 1 cycle from counter state; hsync, vsync and at_display are delayed to stay aligned with color.
REQ-028 SHALL: frame_cnt increments on each frame_start pulse, wrapping 255->0; the first frame_start after reset does not increment it.
REQ-029 SHALL: an out-of-range cfg_idx (>= NUM_SPR) is accepted and ignored.

Reset
REQ-030 SHALL: while rst=1: Hcnt=Vcnt=0, color=0, at_display=0, frame_start=0, frame_cnt=0, cfg_ready=0, and hsync/vsync at the inactive level (~SYNC_POL).
REQ-031 SHALL: reset clears all shadow and active registers (en=0, x=y=0, flip=0, color=0).
REQ-032 SHALL: reset asserted mid-frame or mid-write overrides everything on the next edge; a write on a reset cycle is discarded.
REQ-033 SHALL: after rst deasserts, counting starts from (0,0), so frame_start is seen one cycle later.

Verification
REQ-034 SHALL: timing -- after reset release, hsync period=800 clks with low pulse 96 clks starting at Hcnt 656; vsync period=525 lines with pulse 2 lines at Vcnt 490.
REQ-035 SHALL: commit -- write sprite0 (x=100, y=50, en=1, color=8'hE0, all-ones bitmap) at Vcnt=200 -> nothing drawn this frame; next frame color=E0 at (100..115, 50..65) and BG elsewhere.
REQ-036 SHALL: priority/flip -- sprites 0 and 1 overlap at (200,100), sprite1 bitmap col 0 only with flip=1 -> overlap pixel shows sprite0 color; sprite1 is drawn at column x+15.
REQ-037 SHALL: handshake -- hold cfg_valid=1 across Hcnt=0, Vcnt=480 -> cfg_ready=0 for exactly that cycle; the write completes the next cycle and takes effect one frame later.
REQ-038 SHALL: edge -- sprite at x=632 -> only columns 632..639 are drawn, with no wrap to column 0; Y_INVERT=1, cfg_y=100 -> sprite top at line 400.
REQ-039 SHALL: reset mid-frame at Vcnt=300 -> all outputs hold reset values, frame_cnt=0, and previously committed sprites are no longer drawn.

Source files
------------

// File: rtl/dpu_sprite_engine.sv
// Sprite overlay engine: raster timing counters, double-buffered sprite registers, fixed-priority compositing.
// Latency: every output is registered exactly one cycle after the raster counter state it describes.
// Backpressure: cfg_ready drops only on the vblank commit cycle and during reset; other writes always land.
module dpu_sprite_engine #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int NUM_SPR  = 4,
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int COORD_W  = 11,
    parameter int COLOR_W  = 8,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0,
    parameter bit SYNC_POL = 1'b0,
    parameter bit Y_INVERT = 1'b0,
    parameter int Y_BASE   = 500,
    localparam int IDX_W   = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [IDX_W-1:0]                  cfg_idx,
    input  logic [COORD_W-1:0]                cfg_x,
    input  logic [COORD_W-1:0]                cfg_y,
    input  logic                              cfg_en,
    input  logic                              cfg_flip,
    input  logic [COLOR_W-1:0]                cfg_color,
    input  logic [NUM_SPR*SPR_H*SPR_W-1:0]    sprite_bitmap,
    output logic                              hsync,
    output logic                              vsync,
    output logic [COLOR_W-1:0]                color,
    output logic                              at_display,
    output logic                              frame_start,
    output logic [7:0]                        frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = COORD_W + 1;
    localparam int RW      = $clog2(SPR_H);
    localparam int CW      = $clog2(SPR_W);
    localparam int BW      = $clog2(NUM_SPR * SPR_H * SPR_W);
    localparam logic signed [DW-1:0] SW_S = DW'(SPR_W);
    localparam logic signed [DW-1:0] SH_S = DW'(SPR_H);

    typedef struct packed {
        logic               en;
        logic               flip;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } spr_t;

    logic [COORD_W-1:0] hcnt, vcnt;
    spr_t               shadow [NUM_SPR];
    spr_t               active [NUM_SPR];
    logic               commit, wr, idx_ok, in_act, hs_raw, vs_raw, frame_pos, seen_first;
    logic [COLOR_W-1:0] pix;

    assign commit    = (hcnt == '0) && (vcnt == COORD_W'(V_ACTIVE));
    assign frame_pos = (hcnt == '0) && (vcnt == '0);
    assign cfg_ready = !rst && !commit;
    assign idx_ok    = int'(cfg_idx) < NUM_SPR;
    assign wr        = cfg_valid && cfg_ready && idx_ok;
    assign in_act    = (hcnt < COORD_W'(H_ACTIVE)) && (vcnt < COORD_W'(V_ACTIVE));
    assign hs_raw    = (hcnt >= COORD_W'(H_ACTIVE + H_FP)) && (hcnt < COORD_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw    = (vcnt >= COORD_W'(V_ACTIVE + V_FP)) && (vcnt < COORD_W'(V_ACTIVE + V_FP + V_SYNC));

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == COORD_W'(H_TOTAL - 1)) begin
            hcnt <= '0;
            vcnt <= (vcnt == COORD_W'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Commit and write never share a cycle because cfg_ready is low on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SPR; s++) begin
                shadow[s] <= '0;
                active[s] <= '0;
            end
        end else begin
            if (wr) begin
                shadow[cfg_idx] <= '{en: cfg_en, flip: cfg_flip, x: cfg_x, y: cfg_y, color: cfg_color};
            end
            if (commit) begin
                active <= shadow;
            end
        end
    end

    // Walk from the highest index down so the lowest-index hit is the last writer.
    always_comb begin
        logic [COORD_W-1:0]    y_eff;
        logic signed [DW-1:0]  dx, dy;
        logic [CW-1:0]         col;
        logic [RW-1:0]         row;
        logic [BW-1:0]         bidx;
        pix   = BG_COLOR;
        y_eff = '0;
        dx    = '0;
        dy    = '0;
        col   = '0;
        row   = '0;
        bidx  = '0;
        for (int s = NUM_SPR - 1; s >= 0; s--) begin
            y_eff = Y_INVERT ? COORD_W'(Y_BASE) - active[s].y : active[s].y;
            dx    = $signed({1'b0, hcnt}) - $signed({1'b0, active[s].x});
            dy    = $signed({1'b0, vcnt}) - $signed({1'b0, y_eff});
            col   = active[s].flip ? CW'(SPR_W - 1) - dx[CW-1:0] : dx[CW-1:0];
            row   = dy[RW-1:0];
            bidx  = BW'((s * SPR_H + int'(row)) * SPR_W + int'(col));
            if (active[s].en && !dx[DW-1] && (dx < SW_S) && !dy[DW-1] && (dy < SH_S)
                && sprite_bitmap[bidx]) begin
                pix = active[s].color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color       <= '0;
            at_display  <= 1'b0;
            hsync       <= !SYNC_POL;
            vsync       <= !SYNC_POL;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            seen_first  <= 1'b0;
        end else begin
            color       <= in_act ? pix : '0;
            at_display  <= in_act;
            hsync       <= hs_raw ? SYNC_POL : !SYNC_POL;
            vsync       <= vs_raw ? SYNC_POL : !SYNC_POL;
            frame_start <= frame_pos;
            if (frame_pos) begin
                seen_first <= 1'b1;
                if (seen_first) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dpu_sprite_engine.sv
// Scoreboarded bench for dpu_sprite_engine on a shrunken raster (80x48 total, 64x40 active).
module tb_dpu_sprite_engine;
    localparam int FRAME = 80 * 48;
    localparam bit [4:0] M_COL = 5'd1, M_DISP = 5'd2, M_SYNC = 5'd4, M_FS = 5'd8, M_RDY = 5'd16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic [1:0]   cfg_idx = '0;
    logic [10:0]  cfg_x = '0, cfg_y = '0;
    logic         cfg_en = 1'b0, cfg_flip = 1'b0;
    logic [7:0]   cfg_color = '0;
    logic [1023:0] bitmap;

    logic cfg_ready, hsync, vsync, at_display, frame_start;
    logic [7:0] color, frame_cnt;
    logic i_cfg_ready, i_hsync, i_vsync, i_at_display, i_frame_start;
    logic [7:0] i_color, i_frame_cnt;

    int cyc = -1;
    int checks = 0;
    int errors = 0;
    int acc;

    always #5 clk = ~clk;
    always @(posedge clk) if (rst) cyc <= -1; else cyc <= cyc + 1;

    dpu_sprite_engine #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en), .cfg_flip(cfg_flip), .cfg_color(cfg_color),
        .sprite_bitmap(bitmap), .hsync(hsync), .vsync(vsync), .color(color),
        .at_display(at_display), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    dpu_sprite_engine #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .Y_INVERT(1'b1), .Y_BASE(40)
    ) dut_inv (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(i_cfg_ready), .cfg_idx(cfg_idx),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en), .cfg_flip(cfg_flip), .cfg_color(cfg_color),
        .sprite_bitmap(bitmap), .hsync(i_hsync), .vsync(i_vsync), .color(i_color),
        .at_display(i_at_display), .frame_start(i_frame_start), .frame_cnt(i_frame_cnt)
    );

    typedef struct {
        int         cyc;
        bit         inv;
        bit [4:0]   m;
        logic [7:0] col;
        logic       disp, hs, vs, fs, rdy;
        logic [7:0] fc;
        string      nm;
    } exp_t;

    exp_t q[$];

    function automatic void ex(int c, bit inv, bit [4:0] m, logic [7:0] col, logic disp,
                               logic hs, logic vs, logic fs, logic [7:0] fc, logic rdy, string nm);
        exp_t e;
        e.cyc = c; e.inv = inv; e.m = m; e.col = col; e.disp = disp; e.hs = hs;
        e.vs = vs; e.fs = fs; e.fc = fc; e.rdy = rdy; e.nm = nm;
        q.push_back(e);
    endfunction

    function automatic void px(int c, logic [7:0] col, logic disp, string nm);
        ex(c, 1'b0, M_COL | M_DISP, col, disp, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, nm);
    endfunction
    function automatic void pxi(int c, logic [7:0] col, string nm);
        ex(c, 1'b1, M_COL | M_DISP, col, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, nm);
    endfunction
    function automatic void sy(int c, logic hs, logic vs, string nm);
        ex(c, 1'b0, M_SYNC, 8'd0, 1'b0, hs, vs, 1'b0, 8'd0, 1'b0, nm);
    endfunction
    function automatic void fsx(int c, logic [7:0] fc, logic [7:0] col, string nm);
        ex(c, 1'b0, M_FS | M_COL | M_DISP, col, 1'b1, 1'b0, 1'b0, 1'b1, fc, 1'b0, nm);
    endfunction
    function automatic void rd(int c, logic r, string nm);
        ex(c, 1'b0, M_RDY, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, r, nm);
    endfunction
    function automatic void rst_e(string nm);
        ex(-1, 1'b0, 5'h1F, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, nm);
    endfunction

    task automatic cmp(string nm, string f, logic [7:0] a, logic [7:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s.%s at cyc %0d: got %h expected %h", nm, f, cyc, a, x);
        end
    endtask

    task automatic compare(exp_t e);
        logic [7:0] ac;
        logic       ad;
        ac = e.inv ? i_color : color;
        ad = e.inv ? i_at_display : at_display;
        if (e.m[0]) cmp(e.nm, "color", ac, e.col);
        if (e.m[1]) cmp(e.nm, "at_display", {7'd0, ad}, {7'd0, e.disp});
        if (e.m[2]) cmp(e.nm, "hsync_vsync", {6'd0, hsync, vsync}, {6'd0, e.hs, e.vs});
        if (e.m[3]) begin
            cmp(e.nm, "frame_start", {7'd0, frame_start}, {7'd0, e.fs});
            if (e.fs) cmp(e.nm, "frame_cnt", frame_cnt, e.fc);
        end
        if (e.m[4]) cmp(e.nm, "cfg_ready", {7'd0, cfg_ready}, {7'd0, e.rdy});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (q.size() > 0 && q[0].cyc < 0) begin
                e = q.pop_front();
                compare(e);
            end
        end else begin
            while (q.size() > 0 && q[0].cyc >= 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: expected at cyc %0d, never sampled (now %0d)", e.nm, e.cyc, cyc);
            end
            while (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                compare(e);
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_write(input int idx, input int x, input int y, input bit en, input bit flip,
                            input logic [7:0] col, output int a);
        int n = 0;
        cfg_valid = 1'b1; cfg_idx = 2'(idx); cfg_x = 11'(x); cfg_y = 11'(y);
        cfg_en = en; cfg_flip = flip; cfg_color = col;
        while (!cfg_ready && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: cfg_ready got 0 expected 1 within %0d cycles", 2 * FRAME);
            a = -1;
        end else begin
            a = cyc + 1;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        // Sprites 0, 2, 3 solid; sprite 1 has only bitmap column 0 set.
        bitmap = '0;
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    if (s != 1 || c == 0) bitmap[(s * 16 + r) * 16 + c] = 1'b1;

        repeat (2) @(negedge clk);
        rst_e("reset_init");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Frame 0: timing, display window, commit-cycle ready.
        fsx(0, 8'd0, 8'h00, "first_frame_start");
        ex(1, 1'b0, M_FS, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, "frame_start_pulse_end");
        px(63, 8'h00, 1'b1, "last_active_col");
        px(64, 8'h00, 1'b0, "first_blank_col");
        sy(67, 1'b1, 1'b1, "hsync_before");
        sy(68, 1'b0, 1'b1, "hsync_start");
        sy(75, 1'b0, 1'b1, "hsync_last");
        sy(76, 1'b1, 1'b1, "hsync_end");
        sy(148, 1'b0, 1'b1, "hsync_line1");
        px(1210, 8'h00, 1'b1, "no_draw_before_commit");
        rd(3198, 1'b1, "ready_pre_commit");
        rd(3199, 1'b0, "ready_commit");
        rd(3200, 1'b1, "ready_post_commit");
        px(3200, 8'h00, 1'b0, "vblank_color");
        sy(3359, 1'b1, 1'b1, "vsync_before");
        sy(3360, 1'b1, 1'b0, "vsync_start");
        sy(3519, 1'b1, 1'b0, "vsync_last");
        sy(3520, 1'b1, 1'b1, "vsync_end");

        wait_cyc(800);
        do_write(0, 10, 15, 1'b1, 1'b0, 8'hE0, acc);

        fsx(3840, 8'd1, 8'h00, "frame1_start");
        px(3840 + 14 * 80 + 10, 8'h00, 1'b1, "spr0_above");
        px(3840 + 15 * 80 + 9, 8'h00, 1'b1, "spr0_left");
        px(3840 + 15 * 80 + 10, 8'hE0, 1'b1, "spr0_topleft");
        px(3840 + 15 * 80 + 26, 8'h00, 1'b1, "spr0_right");
        px(3840 + 30 * 80 + 25, 8'hE0, 1'b1, "spr0_botright");
        px(3840 + 31 * 80 + 10, 8'h00, 1'b1, "spr0_below");

        wait_cyc(3840 + 35 * 80);
        do_write(0, 40, 15, 1'b1, 1'b0, 8'hE0, acc);
        do_write(1, 30, 20, 1'b1, 1'b1, 8'h1C, acc);

        fsx(7680, 8'd2, 8'h00, "frame2_start");
        px(7680 + 15 * 80 + 10, 8'h00, 1'b1, "spr0_old_pos_gone");
        px(7680 + 25 * 80 + 45, 8'hE0, 1'b1, "overlap_priority");
        px(7680 + 32 * 80 + 30, 8'h00, 1'b1, "flip_col_x_blank");
        px(7680 + 32 * 80 + 44, 8'h00, 1'b1, "flip_col_14");
        px(7680 + 32 * 80 + 45, 8'h1C, 1'b1, "flip_col_15");
        px(7680 + 32 * 80 + 46, 8'h00, 1'b1, "flip_col_16");
        rd(10878, 1'b1, "hold_ready_pre");
        rd(10879, 1'b0, "hold_ready_commit");
        rd(10880, 1'b1, "hold_ready_post");

        wait_cyc(10879);
        do_write(2, 0, 0, 1'b1, 1'b0, 8'h03, acc);
        checks++;
        if (acc != 10881) begin
            errors++;
            $display("FAIL held_write_accept: got cyc %0d expected cyc %0d", acc, 10881);
        end

        fsx(11520, 8'd3, 8'h00, "held_write_not_yet");

        wait_cyc(12320);
        do_write(3, 56, 5, 1'b1, 1'b0, 8'h77, acc);

        fsx(15360, 8'd4, 8'h03, "held_write_visible");
        px(15360 + 5 * 80 + 56, 8'h77, 1'b1, "edge_first_col");
        pxi(15360 + 5 * 80 + 56, 8'h00, "inv_not_at_raw_y");
        px(15360 + 5 * 80 + 63, 8'h77, 1'b1, "edge_last_col");
        px(15360 + 15 * 80 + 15, 8'h03, 1'b1, "spr2_corner");
        px(15360 + 18 * 80 + 0, 8'h00, 1'b1, "edge_no_wrap_col0");
        px(15360 + 18 * 80 + 7, 8'h00, 1'b1, "edge_no_wrap_col7");
        px(15360 + 18 * 80 + 56, 8'h77, 1'b1, "edge_row13_first");
        px(15360 + 18 * 80 + 63, 8'h77, 1'b1, "edge_row13_last");
        px(15360 + 18 * 80 + 64, 8'h00, 1'b0, "edge_past_active");
        pxi(15360 + 34 * 80 + 56, 8'h00, "inv_above_top");
        pxi(15360 + 35 * 80 + 56, 8'h77, "inv_top_line");

        wait_cyc(5 * FRAME + 25 * 80);
        rst = 1'b1;
        cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_x = '0; cfg_y = '0;
        cfg_en = 1'b1; cfg_flip = 1'b0; cfg_color = 8'h55;
        @(negedge clk);
        rst_e("reset_midframe");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cfg_valid = 1'b0;

        fsx(0, 8'd0, 8'h00, "restart_frame_start");
        px(18 * 80 + 56, 8'h00, 1'b1, "cleared_spr3");
        px(25 * 80 + 45, 8'h00, 1'b1, "cleared_spr0");
        fsx(3840, 8'd1, 8'h00, "reset_write_discarded");
        px(3840 + 18 * 80 + 56, 8'h00, 1'b1, "cleared_after_commit");

        wait_cyc(5400);
        repeat (2) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expected at cyc %0d, still pending at end", e.nm, e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
